hi_xcorr_ssp_tx: RTL



---
 rtl/hi_xcorr_ssp_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hi_xcorr_ssp_tx.sv
// hi_xcorr_ssp_tx: buffers signed I/Q correlation pairs and
// serializes each as a 16-bit SSP frame (I then Q, MSB first).
module hi_xcorr_ssp_tx #(
  parameter int FIFO_DEPTH = 2,
  parameter int CLK_DIV    = 4
) (
  input  logic                          adc_clk,
  input  logic                          reset,
  input  logic                          corr_valid,
  input  logic [7:0]                    corr_i,
  input  logic [7:0]                    corr_q,
  output logic                          ssp_clk,
  output logic                          ssp_frame,
  output logic                          ssp_din,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(CLK_DIV / 2);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [AW-1:0] A_ONE   = AW'(1);
  localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   C_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_ph;
  logic [15:0]   r_sr;
  logic [3:0]    r_bit;
  logic          r_clk;
  logic          r_frame;
  logic          r_din;

  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          r_ovf;

  logic          w_last;
  logic [PW-1:0] w_ph_nxt;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [15:0]   w_head;

  assign w_last   = (r_ph == PH_LAST);
  assign w_ph_nxt = w_last ? '0 : r_ph + PH_ONE;
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == C_FULL);
  assign w_head   = r_mem[r_rp];

  // Pops happen only on the slot boundary, either from idle or
  // at the end of the last bit so frames run back to back.
  assign w_pop  = w_last && !w_empty &&
                  ((r_state == S_IDLE) || (r_bit == 4'd15));
  assign w_push = corr_valid && (!w_full || w_pop);

  always_ff @(negedge adc_clk) begin
    if (w_push) begin
      r_mem[r_wp] <= {corr_i, corr_q};
    end
  end

  always_ff @(negedge adc_clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + A_ONE;
      end
      if (w_pop) begin
        r_rp <= r_rp + A_ONE;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + C_ONE;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - C_ONE;
      end
      if (corr_valid && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(negedge adc_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ph    <= '0;
      r_sr    <= '0;
      r_bit   <= '0;
      r_clk   <= 1'b0;
      r_frame <= 1'b0;
      r_din   <= 1'b0;
    end else begin
      r_ph  <= w_ph_nxt;
      r_clk <= (w_ph_nxt < PH_HALF);
      if (w_last) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_pop) begin
              r_state <= S_SHIFT;
              r_sr    <= {w_head[14:0], 1'b0};
              r_bit   <= '0;
              r_din   <= w_head[15];
              r_frame <= 1'b1;
            end else begin
              r_din   <= 1'b0;
              r_frame <= 1'b0;
            end
          end
          S_SHIFT: begin
            if (r_bit != 4'd15) begin
              r_bit   <= r_bit + 4'd1;
              r_din   <= r_sr[15];
              r_sr    <= {r_sr[14:0], 1'b0};
              r_frame <= 1'b0;
            end else if (w_pop) begin
              r_sr    <= {w_head[14:0], 1'b0};
              r_bit   <= '0;
              r_din   <= w_head[15];
              r_frame <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_din   <= 1'b0;
              r_frame <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ssp_clk    = r_clk;
  assign ssp_frame  = r_frame;
  assign ssp_din    = r_din;
  assign fifo_level = r_cnt;
  assign overflow   = r_ovf;

endmodule
